// File: rtl/boson_pkg.sv
// Shared timing defaults, FSM state type and small helpers for the Boson video-port model.
package boson_pkg;

  localparam int CNT_W = 10;
  localparam int CMP_W = CNT_W + 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 8;
  localparam int DEF_H_BP     = 16;
  localparam int DEF_V_ACTIVE = 512;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 4;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One extra bit so window limits equal to 1024 still compare correctly.
  function automatic logic in_window(input logic [CMP_W-1:0] x,
                                     input logic [CMP_W-1:0] lo,
                                     input logic [CMP_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [15:0] pattern_word(input logic [CNT_W-1:0] h,
                                               input logic [CNT_W-1:0] v,
                                               input logic [15:0]      fc);
    return 16'(h) + 16'(v) + fc;
  endfunction

endpackage

// File: rtl/boson_timing_gen.sv
// Horizontal/vertical raster counters with wrap and end-of-frame strobe.
module boson_timing_gen
  import boson_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             eof
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic h_last;
  logic v_last;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign eof    = h_last && v_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (adv) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule

// File: rtl/boson_camera.sv
// Boson parallel video-port model: IDLE/RUN control, frame counter and registered raster outputs.
module boson_camera
  import boson_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        cam_valid,
  output logic        cam_hsync,
  output logic        cam_vsync,
  output logic [15:0] cam_data,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CMP_W-1:0] ZERO_L = '0;
  localparam logic [CMP_W-1:0] HA_L   = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] HS_LO  = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_HI  = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] VA_L   = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] VS_LO  = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_HI  = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  state_t           state;
  state_t           state_nxt;
  logic             active_p0;
  logic [CNT_W-1:0] h_p0;
  logic [CNT_W-1:0] v_p0;
  logic             eof_p0;
  logic             vld_p0;
  logic             hsync_p0;
  logic             vsync_p0;

  boson_timing_gen #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_timing (
    .clk  (clk),
    .reset(reset),
    .adv  (active_p0),
    .h    (h_p0),
    .v    (v_p0),
    .eof  (eof_p0)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The IDLE edge that sees en already emits pixel (0,0), so it counts as active.
  always_comb begin
    state_nxt = state;
    active_p0 = 1'b0;
    case (state)
      IDLE: begin
        active_p0 = en;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        active_p0 = 1'b1;
        if (eof_p0 && !en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign vld_p0   = active_p0 && in_window({1'b0, h_p0}, ZERO_L, HA_L)
                              && in_window({1'b0, v_p0}, ZERO_L, VA_L);
  assign hsync_p0 = active_p0 && in_window({1'b0, h_p0}, HS_LO, HS_HI);
  assign vsync_p0 = active_p0 && in_window({1'b0, v_p0}, VS_LO, VS_HI);

  // Stage p0 -> registered outputs (1-clock latency from counter value)
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      cam_valid <= 1'b0;
      cam_hsync <= 1'b0;
      cam_vsync <= 1'b0;
      cam_data  <= '0;
    end else begin
      if (active_p0 && eof_p0) frame_cnt <= frame_cnt + 16'd1;
      cam_valid <= vld_p0;
      cam_hsync <= hsync_p0;
      cam_vsync <= vsync_p0;
      cam_data  <= vld_p0 ? pattern_word(h_p0, v_p0, frame_cnt) : 16'h0000;
    end
  end

endmodule

// File: tb/tb_boson_camera.sv
// Bench for boson_camera: default raster lines, reduced-raster frames, and a 1x1 raster for counter wrap.
module tb_boson_camera;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } cfg_t;

  typedef struct {
    bit run;
    int p;
    int fc;
  } mst_t;

  typedef struct {
    bit          valid, hsync, vsync;
    logic [15:0] data, fc;
  } out_t;

  typedef struct {
    bit          r, e;
    bit          valid, hsync, vsync;
    logic [15:0] data, fc;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default raster
  logic        rst_a = 1'b0, en_a = 1'b0;
  logic        va, hsa, vsa;
  logic [15:0] da, fca;
  boson_camera u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .cam_valid(va), .cam_hsync(hsa),
    .cam_vsync(vsa), .cam_data(da), .frame_cnt(fca)
  );

  // Instance B: 7x6 raster
  logic        rst_b = 1'b0, en_b = 1'b0;
  logic        vb, hsb, vsb;
  logic [15:0] db, fcb;
  boson_camera #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .cam_valid(vb), .cam_hsync(hsb),
    .cam_vsync(vsb), .cam_data(db), .frame_cnt(fcb)
  );

  // Instance C: 1x1 raster, one frame per clock
  logic        rst_c = 1'b0, en_c = 1'b0;
  logic        vc, hsc, vsc;
  logic [15:0] dc, fcc;
  boson_camera #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
  ) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .cam_valid(vc), .cam_hsync(hsc),
    .cam_vsync(vsc), .cam_data(dc), .frame_cnt(fcc)
  );

  cfg_t cfg_a = '{640, 16, 8, 16, 512, 2, 2, 4};
  cfg_t cfg_b = '{4, 1, 1, 1, 3, 1, 1, 1};
  mst_t ms_a  = '{0, 0, 0};
  mst_t ms_b  = '{0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame position is a single linear pixel index; h/v derived by division.
  task automatic model(input cfg_t c, inout mst_t s, input bit r, input bit e, output out_t o);
    int htot, vtot, h, v;
    htot = c.ha + c.hf + c.hs + c.hb;
    vtot = c.va + c.vf + c.vs + c.vb;
    o = '{0, 0, 0, 16'h0, 16'h0};
    if (!r) begin
      s = '{0, 0, 0};
      return;
    end
    if (s.run || e) begin
      h = s.p % htot;
      v = s.p / htot;
      o.valid = (h < c.ha) && (v < c.va);
      o.hsync = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
      o.vsync = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
      o.data  = o.valid ? 16'((h + v + s.fc) % 65536) : 16'h0;
      if (s.p == htot * vtot - 1) begin
        s.fc  = (s.fc + 1) % 65536;
        s.p   = 0;
        s.run = e;
      end else begin
        s.p   = s.p + 1;
        s.run = 1;
      end
    end
    o.fc = 16'(s.fc);
  endtask

  task automatic step_a(input bit r, input bit e);
    out_t o;
    rst_a = r; en_a = e;
    model(cfg_a, ms_a, r, e, o);
    @(posedge clk); @(negedge clk);
    chk("A_out", {29'd0, va, hsa, vsa, da, fca}, {29'd0, o.valid, o.hsync, o.vsync, o.data, o.fc});
  endtask

  task automatic step_b(input bit r, input bit e);
    out_t o;
    rst_b = r; en_b = e;
    model(cfg_b, ms_b, r, e, o);
    @(posedge clk); @(negedge clk);
    chk("B_out", {29'd0, vb, hsb, vsb, db, fcb}, {29'd0, o.valid, o.hsync, o.vsync, o.data, o.fc});
  endtask

  task automatic run_a;
    int nvalid, hs_first, hs_cnt;
    for (int i = 0; i < 5; i++) begin
      step_a(0, 1);
      chk("A_reset_quiet", {va, hsa, vsa, da, fca}, '0);
    end
    nvalid = 0; hs_first = -1; hs_cnt = 0;
    for (int i = 0; i < 680; i++) begin
      step_a(1, 1);
      if (i == 0) chk("A_first_pixel", {va, da}, {1'b1, 16'd0});
      if (i == 639) chk("A_last_pixel", {va, da}, {1'b1, 16'd639});
      nvalid += int'(va);
      if (hsa) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
    end
    chk("A_line0_valid_cnt", nvalid, 640);
    chk("A_hsync_start", hs_first, 656);
    chk("A_hsync_len", hs_cnt, 8);
    step_a(1, 1);
    chk("A_line1_first_data", da, 16'd1);
    for (int i = 0; i < 1400; i++) step_a(1, 1'($urandom_range(0, 1)));
    step_a(0, 1);
    chk("A_midframe_reset", {va, hsa, vsa, da, fca}, '0);
    step_a(1, 1);
    chk("A_restart", {va, da, fca}, {1'b1, 16'd0, 16'd0});
    for (int i = 0; i < 20; i++) step_a(1, 1);
  endtask

  task automatic run_b;
    vec_t tbl[11];
    tbl[0]  = '{0, 1, 0, 0, 0, 16'd0, 16'd0};
    tbl[1]  = '{1, 0, 0, 0, 0, 16'd0, 16'd0};
    tbl[2]  = '{1, 1, 1, 0, 0, 16'd0, 16'd0};
    tbl[3]  = '{1, 1, 1, 0, 0, 16'd1, 16'd0};
    tbl[4]  = '{1, 1, 1, 0, 0, 16'd2, 16'd0};
    tbl[5]  = '{1, 1, 1, 0, 0, 16'd3, 16'd0};
    tbl[6]  = '{1, 1, 0, 0, 0, 16'd0, 16'd0};
    tbl[7]  = '{1, 1, 0, 1, 0, 16'd0, 16'd0};
    tbl[8]  = '{1, 1, 0, 0, 0, 16'd0, 16'd0};
    tbl[9]  = '{1, 1, 1, 0, 0, 16'd1, 16'd0};
    tbl[10] = '{1, 0, 1, 0, 0, 16'd2, 16'd0};
    for (int i = 0; i < 11; i++) begin
      rst_b = tbl[i].r; en_b = tbl[i].e;
      @(posedge clk); @(negedge clk);
      chk($sformatf("B_tbl%0d", i), {vb, hsb, vsb, db, fcb},
          {tbl[i].valid, tbl[i].hsync, tbl[i].vsync, tbl[i].data, tbl[i].fc});
    end
    step_b(0, 0);
    for (int i = 0; i < 62; i++) step_b(1, 1);
    chk("B_fc_after_frame0", fcb, 16'd1);
    for (int i = 0; i < 22; i++) step_b(1, 0);
    chk("B_fc_after_drop", fcb, 16'd2);
    for (int i = 0; i < 10; i++) begin
      step_b(1, 0);
      chk("B_idle_quiet", {vb, hsb, vsb, db}, '0);
    end
    step_b(1, 1);
    chk("B_restart_data", {vb, db}, {1'b1, 16'd2});
    for (int i = 0; i < 3000; i++)
      step_b(($urandom % 500) != 0, ($urandom % 8) != 0);
  endtask

  task automatic run_c;
    rst_c = 1'b0; en_c = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("C_reset", {vc, dc, fcc}, '0);
    rst_c = 1'b1;
    for (int n = 1; n <= 65537; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1 || n >= 65535) begin
        chk("C_fc", fcc, 64'(n % 65536));
        chk("C_data", {vc, dc}, {1'b1, 16'((n - 1) % 65536)});
      end
    end
  endtask

  initial begin
    fork
      begin run_a(); run_b(); end
      run_c();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
